// File: rtl/filter_sample_sequencer_pkg.sv
// Shared types and constants for the filter sample sequencer and its watchdog.
package filter_sample_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTrig = 2'd1,
    StWait = 2'd2,
    StOut  = 2'd3
  } seq_state_e;

  localparam int unsigned DefaultDataSize = 24;
  localparam int unsigned CoefSize        = 20;

  // A disabled watchdog (timeout 0) still needs a one-bit counter to stay legal.
  function automatic int unsigned wd_cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/filter_sample_sequencer_watchdog.sv
// Cycle counter for the WAIT state; flags the last permitted cycle before a chain is declared hung.
module filter_sample_sequencer_watchdog
  import filter_sample_sequencer_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = wd_cnt_width(TimeoutCycles);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (TimeoutCycles == 0) begin : g_disabled
    assign expire_o = 1'b0;
  end else begin : g_enabled
    assign expire_o = en_i && (cnt_q == CntW'(TimeoutCycles - 1));
  end

endmodule

// File: rtl/filter_sample_sequencer.sv
// Initiator of the sample_trig / filter_done handshake: holds a sample on the filter chain,
// triggers it, waits for completion and hands the result downstream, with sticky error flags.
module filter_sample_sequencer
  import filter_sample_sequencer_pkg::*;
#(
  parameter int unsigned DataSize      = DefaultDataSize,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntSize       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DataSize-1:0] s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [DataSize-1:0] flt_data_in_o,
  output logic                flt_sample_trig_o,
  input  logic                flt_done_i,
  input  logic [DataSize-1:0] flt_data_out_i,
  output logic [DataSize-1:0] m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                err_timeout_o,
  output logic                err_spurious_o,
  input  logic                err_clear_i,
  output logic [CntSize-1:0]  sample_count_o
);

  seq_state_e          state_q;
  logic [DataSize-1:0] flt_data_in_q;
  logic                flt_sample_trig_q;
  logic [DataSize-1:0] m_data_q;
  logic                m_valid_q;
  logic                err_timeout_q;
  logic                err_spurious_q;
  logic [CntSize-1:0]  sample_count_q;

  logic wd_expire;
  logic timeout_hit;
  logic spurious_hit;

  filter_sample_sequencer_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (state_q == StTrig),
    .en_i    (state_q == StWait),
    .expire_o(wd_expire)
  );

  // A completion arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit  = (state_q == StWait) && !flt_done_i && wd_expire;
  assign spurious_hit = flt_done_i && (state_q != StWait);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= StIdle;
      flt_data_in_q     <= '0;
      flt_sample_trig_q <= 1'b0;
      m_data_q          <= '0;
      m_valid_q         <= 1'b0;
      err_timeout_q     <= 1'b0;
      err_spurious_q    <= 1'b0;
      sample_count_q    <= '0;
    end else begin
      flt_sample_trig_q <= 1'b0;

      if (timeout_hit) begin
        err_timeout_q <= 1'b1;
      end else if (err_clear_i) begin
        err_timeout_q <= 1'b0;
      end

      if (spurious_hit) begin
        err_spurious_q <= 1'b1;
      end else if (err_clear_i) begin
        err_spurious_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (s_valid_i) begin
            flt_data_in_q     <= s_data_i;
            flt_sample_trig_q <= 1'b1;
            state_q           <= StTrig;
          end
        end
        StTrig: state_q <= StWait;
        StWait: begin
          if (flt_done_i) begin
            m_data_q       <= flt_data_out_i;
            m_valid_q      <= 1'b1;
            sample_count_q <= sample_count_q + CntSize'(1);
            state_q        <= StOut;
          end else if (timeout_hit) begin
            state_q <= StIdle;
          end
        end
        StOut: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_ready_o         = (state_q == StIdle) && rst_ni;
  assign busy_o            = (state_q != StIdle);
  assign flt_data_in_o     = flt_data_in_q;
  assign flt_sample_trig_o = flt_sample_trig_q;
  assign m_data_o          = m_data_q;
  assign m_valid_o         = m_valid_q;
  assign err_timeout_o     = err_timeout_q;
  assign err_spurious_o    = err_spurious_q;
  assign sample_count_o    = sample_count_q;

endmodule

// File: tb/tb_filter_sample_sequencer.sv
// Self-checking bench for filter_sample_sequencer: directed vector table, corner sequences and
// randomized transactions against a transaction-level model of the chain and sample counter.
module tb_filter_sample_sequencer;

  localparam int unsigned DW   = 24;
  localparam int unsigned TO   = 16;
  localparam int unsigned CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] flt_data_in;
  logic          flt_trig;
  logic          flt_done;
  logic [DW-1:0] flt_data_out;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          err_timeout;
  logic          err_spurious;
  logic          err_clear;
  logic [CW-1:0] sample_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  filter_sample_sequencer #(
    .DataSize(DW),
    .TimeoutCycles(TO),
    .CntSize(CW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .s_data_i         (s_data),
    .s_valid_i        (s_valid),
    .s_ready_o        (s_ready),
    .flt_data_in_o    (flt_data_in),
    .flt_sample_trig_o(flt_trig),
    .flt_done_i       (flt_done),
    .flt_data_out_i   (flt_data_out),
    .m_data_o         (m_data),
    .m_valid_o        (m_valid),
    .m_ready_i        (m_ready),
    .busy_o           (busy),
    .err_timeout_o    (err_timeout),
    .err_spurious_o   (err_spurious),
    .err_clear_i      (err_clear),
    .sample_count_o   (sample_count)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] res;
    int            lat;
    int            hold;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction; chain answers lat cycles after trig, sink stalls hold cycles.
  task automatic do_sample(input logic [DW-1:0] din, input logic [DW-1:0] res, input int lat,
                           input int hold, input logic [DW-1:0] exp_data);
    check("s_ready_idle", 32'(s_ready), 32'd1);
    s_data  = din;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_data  = 24'($urandom);
    check("trig_high", 32'(flt_trig), 32'd1);
    check("flt_data_in", 32'(flt_data_in), 32'(din));
    check("busy_trig", 32'(busy), 32'd1);
    step();
    check("trig_one_cycle", 32'(flt_trig), 32'd0);
    for (int i = 1; i < lat; i++) begin
      check("no_early_valid", 32'(m_valid), 32'd0);
      check("flt_data_held", 32'(flt_data_in), 32'(din));
      step();
    end
    flt_done     = 1'b1;
    flt_data_out = res;
    step();
    flt_done     = 1'b0;
    flt_data_out = 24'($urandom);
    exp_count    = (exp_count + 1) % (1 << CW);
    check("m_valid", 32'(m_valid), 32'd1);
    check("m_data", 32'(m_data), 32'(exp_data));
    check("sample_count", 32'(sample_count), 32'(exp_count));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(exp_data));
      check("hold_s_ready", 32'(s_ready), 32'd0);
      check("hold_no_trig", 32'(flt_trig), 32'd0);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("out_release_valid", 32'(m_valid), 32'd0);
    check("out_release_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{din: 24'h123456, res: 24'h0ABCDE, lat: 6,  hold: 0,  exp_data: 24'h0ABCDE};
    vecs[1] = '{din: 24'hA5A5A5, res: 24'h5A5A5A, lat: 2,  hold: 10, exp_data: 24'h5A5A5A};
    vecs[2] = '{din: 24'h000001, res: 24'h800000, lat: 1,  hold: 0,  exp_data: 24'h800000};
    vecs[3] = '{din: 24'h7FFFFF, res: 24'h13579B, lat: 16, hold: 0,  exp_data: 24'h13579B};
    vecs[4] = '{din: 24'hFFFFFF, res: 24'h000000, lat: 3,  hold: 1,  exp_data: 24'h000000};

    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; flt_done = 1'b0; flt_data_out = '0;
    m_ready = 1'b0; err_clear = 1'b0;
    step();
    step();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    check("post_rst_errs", 32'({err_timeout, err_spurious}), 32'd0);

    for (int v = 0; v < 5; v++) begin
      do_sample(vecs[v].din, vecs[v].res, vecs[v].lat, vecs[v].hold, vecs[v].exp_data);
    end
    check("table_no_errs", 32'({err_timeout, err_spurious}), 32'd0);

    // Reset mid-WAIT aborts silently.
    s_data = 24'hC0FFEE; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    step();
    check("midwait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_sready", 32'(s_ready), 32'd0);
    step();
    check("midwait_rst_busy", 32'(busy), 32'd0);
    check("midwait_rst_data_in", 32'(flt_data_in), 32'd0);
    check("midwait_rst_m_data", 32'(m_data), 32'd0);
    check("midwait_rst_trig", 32'(flt_trig), 32'd0);
    check("midwait_rst_count", 32'(sample_count), 32'd0);
    rst_n = 1'b1;
    exp_count = 0;
    step();
    check("midwait_post_sready", 32'(s_ready), 32'd1);
    check("midwait_no_valid", 32'(m_valid), 32'd0);

    // Hung chain: timeout after exactly TO WAIT cycles.
    s_data = 24'h424242; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    for (int i = 0; i < int'(TO) - 1; i++) step();
    check("to_still_waiting", 32'(busy), 32'd1);
    check("to_not_yet", 32'(err_timeout), 32'd0);
    step();
    check("to_flag", 32'(err_timeout), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    check("to_no_valid", 32'(m_valid), 32'd0);
    check("to_count_kept", 32'(sample_count), 32'(exp_count));
    check("to_s_ready", 32'(s_ready), 32'd1);

    // Spurious done in IDLE, then clear; set beats clear.
    flt_done = 1'b1; flt_data_out = 24'hDEAD00;
    step();
    flt_done = 1'b0;
    check("spur_flag", 32'(err_spurious), 32'd1);
    check("spur_no_valid", 32'(m_valid), 32'd0);
    check("spur_idle", 32'(busy), 32'd0);
    flt_done = 1'b1; err_clear = 1'b1;
    step();
    flt_done = 1'b0;
    check("set_wins_spur", 32'(err_spurious), 32'd1);
    check("clear_timeout", 32'(err_timeout), 32'd0);
    step();
    err_clear = 1'b0;
    check("clear_both", 32'({err_timeout, err_spurious}), 32'd0);
    step();
    check("flags_stay_clear", 32'({err_timeout, err_spurious}), 32'd0);

    // Randomized traffic; enough samples to wrap the counter twice.
    for (int n = 0; n < 600; n++) begin
      logic [DW-1:0] din;
      logic [DW-1:0] res;
      int lat;
      int hold;
      din  = 24'($urandom);
      res  = 24'($urandom);
      lat  = int'($urandom_range(1, TO));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_sample(din, res, lat, hold, res);
    end
    check("rand_no_errs", 32'({err_timeout, err_spurious}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
